// File: rtl/multicycle_pkg.sv
//==============================================================================
// Module      : multicycle_pkg
// Description : Shared op codes, FSM states and ALU selects for multicycle_datapath.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

package multicycle_pkg;

    localparam logic [6:0] c_OP_NONE  = 7'h00;
    localparam logic [6:0] c_OP_LI    = 7'h01;
    localparam logic [6:0] c_OP_ADD   = 7'h02;
    localparam logic [6:0] c_OP_SUB   = 7'h03;
    localparam logic [6:0] c_OP_STORE = 7'h04;
    localparam logic [6:0] c_OP_LOAD  = 7'h05;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        READ   = 3'd1,
        EXEC   = 3'd2,
        MEM_WR = 3'd3,
        MEM_RD = 3'd4,
        WB     = 3'd5,
        DONE   = 3'd6
    } state_t;

    typedef enum logic [1:0] {
        ALU_PASS = 2'd0,
        ALU_ADD  = 2'd1,
        ALU_SUB  = 2'd2
    } alu_fn_t;

    function automatic logic is_legal_op(input logic [6:0] op);
        return (op <= c_OP_LOAD);
    endfunction

endpackage

`default_nettype wire

// File: rtl/mc_alu.sv
//==============================================================================
// Module      : mc_alu
// Description : Combinational pass/add/sub unit with signed-overflow flag.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module mc_alu
    import multicycle_pkg::*;
#(
    parameter int WORDSIZE = 64
) (
    input  alu_fn_t             i_fn,
    input  logic [WORDSIZE-1:0] i_a,
    input  logic [WORDSIZE-1:0] i_b,
    output logic [WORDSIZE-1:0] o_y,
    output logic                o_ovf
);

    localparam int c_MSB = WORDSIZE - 1;

    always_comb begin
        o_y   = i_a;
        o_ovf = 1'b0;
        case (i_fn)
            ALU_ADD: begin
                o_y   = i_a + i_b;
                o_ovf = (i_a[c_MSB] == i_b[c_MSB]) && (o_y[c_MSB] != i_a[c_MSB]);
            end
            ALU_SUB: begin
                o_y   = i_a - i_b;
                o_ovf = (i_a[c_MSB] != i_b[c_MSB]) && (o_y[c_MSB] != i_a[c_MSB]);
            end
            default: begin
                o_y   = i_a;
                o_ovf = 1'b0;
            end
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/multicycle_datapath.sv
//==============================================================================
// Module      : multicycle_datapath
// Description : One instruction per start/done handshake over an internal
//               register file and data memory. Optional macro ZERO_REG_EN
//               hard-wires register 0 to zero.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module multicycle_datapath
    import multicycle_pkg::*;
#(
    parameter int WORDSIZE = 64,
    parameter int SIZE     = 32,
    parameter int DM_DEPTH = 32
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        start,
    input  logic [6:0]                  op_code,
    input  logic [$clog2(SIZE)-1:0]     rs1,
    input  logic [$clog2(SIZE)-1:0]     rs2,
    input  logic [$clog2(SIZE)-1:0]     rd,
    input  logic [WORDSIZE-1:0]         imm,
    output logic                        busy,
    output logic                        done,
    output logic                        error,
    output logic                        overflow,
    output logic [WORDSIZE-1:0]         result
);

    localparam int c_RA = $clog2(SIZE);
    localparam int c_MA = $clog2(DM_DEPTH);

    state_t              r_state;
    logic [6:0]          r_op;
    logic [c_RA-1:0]     r_rs1;
    logic [c_RA-1:0]     r_rs2;
    logic [c_RA-1:0]     r_rd;
    logic [WORDSIZE-1:0] r_imm;
    logic [WORDSIZE-1:0] r_a;
    logic [WORDSIZE-1:0] r_b;
    logic [WORDSIZE-1:0] r_res;
    logic                r_ovf;
    logic                r_err;
    logic [c_MA-1:0]     r_addr;
    logic [WORDSIZE-1:0] r_dm_q;

    logic [WORDSIZE-1:0] r_rf [SIZE];
    logic [WORDSIZE-1:0] r_dm [DM_DEPTH];

    logic [WORDSIZE-1:0] w_rs1_val;
    logic [WORDSIZE-1:0] w_rs2_val;
    logic                w_rf_we;
    logic                w_dm_we;
    logic [WORDSIZE-1:0] w_wb_data;
    logic [WORDSIZE-1:0] w_alu_a;
    logic [WORDSIZE-1:0] w_alu_b;
    logic [WORDSIZE-1:0] w_alu_y;
    logic                w_alu_ovf;
    alu_fn_t             w_alu_fn;

`ifdef ZERO_REG_EN
    assign w_rs1_val = (r_rs1 == '0) ? '0 : r_rf[r_rs1];
    assign w_rs2_val = (r_rs2 == '0) ? '0 : r_rf[r_rs2];
    assign w_rf_we   = (r_state == WB) && (r_rd != '0);
`else
    assign w_rs1_val = r_rf[r_rs1];
    assign w_rs2_val = r_rf[r_rs2];
    assign w_rf_we   = (r_state == WB);
`endif

    // A reset landing in MEM_WR has already forced IDLE; rst also gates the edge itself.
    assign w_dm_we   = (r_state == MEM_WR) && !rst;
    assign w_wb_data = (r_op == c_OP_LOAD) ? r_dm_q : r_res;

    always_comb begin
        w_alu_a  = r_a;
        w_alu_b  = r_b;
        w_alu_fn = ALU_PASS;
        case (r_op)
            c_OP_LI:    w_alu_a = r_imm;
            c_OP_ADD:   w_alu_fn = ALU_ADD;
            c_OP_SUB:   w_alu_fn = ALU_SUB;
            c_OP_STORE,
            c_OP_LOAD: begin
                w_alu_b  = r_imm;
                w_alu_fn = ALU_ADD;
            end
            default:    w_alu_fn = ALU_PASS;
        endcase
    end

    mc_alu #(
        .WORDSIZE (WORDSIZE)
    ) u_alu (
        .i_fn  (w_alu_fn),
        .i_a   (w_alu_a),
        .i_b   (w_alu_b),
        .o_y   (w_alu_y),
        .o_ovf (w_alu_ovf)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= IDLE;
            r_op     <= '0;
            r_rs1    <= '0;
            r_rs2    <= '0;
            r_rd     <= '0;
            r_imm    <= '0;
            r_a      <= '0;
            r_b      <= '0;
            r_res    <= '0;
            r_ovf    <= 1'b0;
            r_err    <= 1'b0;
            r_addr   <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            error    <= 1'b0;
            overflow <= 1'b0;
            result   <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    done <= 1'b0;
                    busy <= start;
                    if (start) begin
                        r_op    <= op_code;
                        r_rs1   <= rs1;
                        r_rs2   <= rs2;
                        r_rd    <= rd;
                        r_imm   <= imm;
                        r_state <= READ;
                    end
                end
                READ: begin
                    r_a <= w_rs1_val;
                    r_b <= w_rs2_val;
                    if (!is_legal_op(r_op) || (r_op == c_OP_NONE)) begin
                        r_res   <= '0;
                        r_ovf   <= 1'b0;
                        r_err   <= !is_legal_op(r_op);
                        r_state <= DONE;
                    end else begin
                        r_err   <= 1'b0;
                        r_state <= EXEC;
                    end
                end
                EXEC: begin
                    r_addr <= w_alu_y[c_MA-1:0];
                    r_ovf  <= ((r_op == c_OP_ADD) || (r_op == c_OP_SUB)) ? w_alu_ovf : 1'b0;
                    r_res  <= (r_op == c_OP_STORE) ? r_b : w_alu_y;
                    case (r_op)
                        c_OP_STORE: r_state <= MEM_WR;
                        c_OP_LOAD:  r_state <= MEM_RD;
                        default:    r_state <= WB;
                    endcase
                end
                MEM_WR: r_state <= DONE;
                MEM_RD: r_state <= WB;
                WB: begin
                    r_res   <= w_wb_data;
                    r_state <= DONE;
                end
                DONE: begin
                    done     <= 1'b1;
                    error    <= r_err;
                    overflow <= r_ovf;
                    result   <= r_res;
                    r_state  <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < SIZE; i++) begin
                r_rf[i] <= '0;
            end
        end else if (w_rf_we) begin
            r_rf[r_rd] <= w_wb_data;
        end
    end

    // Data memory has no reset so it can map onto a plain synchronous RAM.
    always_ff @(posedge clk) begin
        if (w_dm_we) begin
            r_dm[r_addr] <= r_b;
        end
        if (r_state == MEM_RD) begin
            r_dm_q <= r_dm[r_addr];
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_multicycle_datapath.sv
//==============================================================================
// Module      : tb_multicycle_datapath
// Description : Directed plus randomized checks of multicycle_datapath against
//               an instruction-level model. Honours macro ZERO_REG_EN.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_multicycle_datapath;

    localparam int W    = 64;
    localparam int SIZE = 32;
    localparam int DM   = 32;
    localparam int RA   = $clog2(SIZE);

    localparam logic [6:0] NONE_OP = 7'h00;
    localparam logic [6:0] LI_OP   = 7'h01;
    localparam logic [6:0] ADD_OP  = 7'h02;
    localparam logic [6:0] SUB_OP  = 7'h03;
    localparam logic [6:0] ST_OP   = 7'h04;
    localparam logic [6:0] LD_OP   = 7'h05;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic [6:0]    op_code = '0;
    logic [RA-1:0] rs1 = '0;
    logic [RA-1:0] rs2 = '0;
    logic [RA-1:0] rd = '0;
    logic [W-1:0]  imm = '0;
    logic          busy;
    logic          done;
    logic          error;
    logic          overflow;
    logic [W-1:0]  result;

    int checks = 0;
    int errors = 0;

    logic [W-1:0] m_rf [SIZE];
    logic [W-1:0] m_dm [DM];
    logic [W-1:0] last_res;
    logic         last_ovf;
    logic         last_err;

    multicycle_datapath #(
        .WORDSIZE (W),
        .SIZE     (SIZE),
        .DM_DEPTH (DM)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .op_code  (op_code),
        .rs1      (rs1),
        .rs2      (rs2),
        .rd       (rd),
        .imm      (imm),
        .busy     (busy),
        .done     (done),
        .error    (error),
        .overflow (overflow),
        .result   (result)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [W-1:0] mrd(input int i);
`ifdef ZERO_REG_EN
        if (i == 0) return '0;
`endif
        return m_rf[i];
    endfunction

    task automatic mwr(input int i, input logic [W-1:0] v);
`ifdef ZERO_REG_EN
        if (i == 0) return;
`endif
        m_rf[i] = v;
    endtask

    function automatic logic signed_ovf(input logic [W-1:0] a, input logic [W-1:0] b, input bit sub);
        logic signed [W+1:0] sa, sb, sx, smax, smin;
        sa   = $signed({{2{a[W-1]}}, a});
        sb   = $signed({{2{b[W-1]}}, b});
        sx   = sub ? (sa - sb) : (sa + sb);
        smax = $signed({3'b000, {(W-1){1'b1}}});
        smin = -smax - 1;
        return (sx > smax) || (sx < smin);
    endfunction

    task automatic model_reset();
        for (int i = 0; i < SIZE; i++) m_rf[i] = '0;
    endtask

    // Issue one instruction, optionally poking start with garbage while busy.
    task automatic exec(input logic [6:0] op, input int s1, input int s2, input int d,
                        input logic [W-1:0] im);
        logic [W-1:0] a, b, res;
        logic         err, ovf;
        int           lat, addr, k;
        bit           seen;
        a = mrd(s1); b = mrd(s2);
        res = '0; err = 1'b0; ovf = 1'b0; lat = 4;
        case (op)
            NONE_OP: lat = 2;
            LI_OP:   begin res = im; mwr(d, res); end
            ADD_OP:  begin res = a + b; ovf = signed_ovf(a, b, 1'b0); mwr(d, res); end
            SUB_OP:  begin res = a - b; ovf = signed_ovf(a, b, 1'b1); mwr(d, res); end
            ST_OP:   begin addr = int'((a + im) % DM); m_dm[addr] = b; res = b; end
            LD_OP:   begin lat = 5; addr = int'((a + im) % DM); res = m_dm[addr]; mwr(d, res); end
            default: begin lat = 2; err = 1'b1; end
        endcase

        @(negedge clk);
        op_code = op; rs1 = s1[RA-1:0]; rs2 = s2[RA-1:0]; rd = d[RA-1:0]; imm = im;
        start = 1'b1;
        @(posedge clk); #1;
        chk("busy_rise", {63'd0, busy}, 64'd1);
        @(negedge clk);
        start = ($urandom_range(0, 1) == 1);
        op_code = 7'($urandom()); rs1 = RA'($urandom()); rs2 = RA'($urandom());
        rd = RA'($urandom()); imm = {$urandom(), $urandom()};
        seen = 1'b0;
        for (k = 1; k <= 12; k++) begin
            @(posedge clk); #1;
            if (done) begin seen = 1'b1; break; end
            @(negedge clk);
            start = 1'b0;
        end
        if (!seen) begin
            chk("done_timeout", 64'd0, 64'd1);
        end else begin
            last_res = result; last_ovf = overflow; last_err = error;
            chk("latency", 64'(k), 64'(lat));
            chk("result", result, res);
            chk("error", {63'd0, error}, {63'd0, err});
            chk("overflow", {63'd0, overflow}, {63'd0, ovf});
            chk("busy_with_done", {63'd0, busy}, 64'd1);
            @(posedge clk); #1;
            chk("done_single", {63'd0, done}, 64'd0);
            chk("busy_fall", {63'd0, busy}, 64'd0);
        end
    endtask

    initial begin
        int r1, r2, rdi, sel;
        logic [6:0] rop;
        model_reset();

        #12;
        chk("rst_busy", {63'd0, busy}, 64'd0);
        chk("rst_done", {63'd0, done}, 64'd0);
        chk("rst_error", {63'd0, error}, 64'd0);
        chk("rst_overflow", {63'd0, overflow}, 64'd0);
        chk("rst_result", result, 64'd0);
        @(negedge clk);
        rst = 1'b0;

        exec(LI_OP, 0, 0, 1, 64'd5);
        exec(LI_OP, 0, 0, 2, 64'd3);
        exec(ADD_OP, 1, 2, 3, 64'd0);
        chk("add_8", last_res, 64'd8);
        chk("add_8_ovf", {63'd0, last_ovf}, 64'd0);
        exec(SUB_OP, 2, 1, 4, 64'd0);
        chk("sub_m2", last_res, 64'hFFFF_FFFF_FFFF_FFFE);

        exec(LI_OP, 0, 0, 5, 64'(DM + 2));
        exec(ST_OP, 5, 3, 0, 64'd1);
        exec(LD_OP, 0, 0, 6, 64'd3);
        chk("load_wrap", last_res, 64'd8);

        exec(LI_OP, 0, 0, 20, 64'h7FFF_FFFF_FFFF_FFFF);
        exec(LI_OP, 0, 0, 21, 64'd1);
        exec(ADD_OP, 20, 21, 22, 64'd0);
        chk("add_ovf_res", last_res, 64'h8000_0000_0000_0000);
        chk("add_ovf", {63'd0, last_ovf}, 64'd1);
        exec(SUB_OP, 22, 21, 23, 64'd0);
        chk("sub_ovf", {63'd0, last_ovf}, 64'd1);

        exec(7'h7F, 1, 2, 3, 64'd0);
        chk("illegal_err", {63'd0, last_err}, 64'd1);
        exec(ADD_OP, 3, 0, 24, 64'd0);
        exec(NONE_OP, 1, 2, 3, 64'd0);

        exec(LI_OP, 0, 0, 0, 64'd9);
        exec(ADD_OP, 0, 0, 7, 64'd0);
`ifdef ZERO_REG_EN
        chk("zero_reg", last_res, 64'd0);
`else
        chk("zero_reg", last_res, 64'd18);
`endif

        exec(LI_OP, 0, 0, 10, 64'd0);
        for (int a = 0; a < DM; a++) begin
            exec(LI_OP, 0, 0, 8, {$urandom(), $urandom()});
            exec(ST_OP, 10, 8, 0, 64'(a));
        end

        for (int n = 0; n < 60; n++) begin
            sel = $urandom_range(0, 8);
            r1  = $urandom_range(0, SIZE - 1);
            r2  = $urandom_range(0, SIZE - 1);
            rdi = $urandom_range(0, SIZE - 1);
            case (sel)
                0: rop = NONE_OP;
                1, 2: rop = LI_OP;
                3: rop = ADD_OP;
                4: rop = SUB_OP;
                5: rop = ST_OP;
                6: rop = LD_OP;
                7: rop = 7'($urandom_range(6, 127));
                default: rop = ($urandom_range(0, 1) == 1) ? ADD_OP : SUB_OP;
            endcase
            exec(rop, r1, r2, rdi, {$urandom(), $urandom()});
        end

        // Reset in the middle of an ADD.
        exec(LI_OP, 0, 0, 11, 64'h1234_5678_9ABC_DEF0);
        @(negedge clk);
        op_code = ADD_OP; rs1 = 5'd11; rs2 = 5'd11; rd = 5'd12; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("midrst_busy", {63'd0, busy}, 64'd0);
        chk("midrst_done", {63'd0, done}, 64'd0);
        chk("midrst_error", {63'd0, error}, 64'd0);
        chk("midrst_overflow", {63'd0, overflow}, 64'd0);
        chk("midrst_result", result, 64'd0);
        model_reset();
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        exec(LI_OP, 0, 0, 13, 64'd5);
        exec(ADD_OP, 12, 12, 14, 64'd0);
        chk("midrst_rd_zero", last_res, 64'd0);
        exec(ADD_OP, 13, 11, 15, 64'd0);
        chk("midrst_li_ok", last_res, 64'd5);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
